alu_ctrl_md: RTL and testbench
==============================

# alu_ctrl_md

Parametrised EX-stage ALU controller for the pipelined MIPS core.
- Decodes `ALUOp_i`/`funct_i` into the 4-bit ALU control code.
- Owns a sequential, iterative multiply/divide engine with HI/LO registers, so mult/multu/div/divu/mfhi/mflo execute without a combinational multiplier.
- Raises `stall_o` to the hazard unit whenever the EX instruction needs the busy engine.

## Interface
- `DATA_W`, 32: operand/HI/LO width; even, ≥ 8.
- `FUNCT_W`, 6: funct field width.
- `ALUOP_W`, 3: ALUOp width.
- `clk_i`  in  1  core clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  EX stage holds a real instruction.
- `ALUOp_i`  in  ALUOP_W  from main decoder.
- `funct_i`  in  FUNCT_W  instruction funct field.
- `src1_i`, `src2_i`  in  DATA_W  rs/rt operand values.
- `ALUCtrl_o`  out  4  ALU operation code.
- `stall_o`  out  1  hold IF/ID/EX this cycle.
- `busy_o`  out  1  engine not IDLE.
- `md_result_o`  out  DATA_W  HI/LO read data for mfhi/mflo; 0 otherwise.

## Operation
- **Decode.** `ALUCtrl_o` is combinational and independent of reset.
  - ALUOp 0 → 0010. ALUOp 1 → 0111.
  - ALUOp 3 with funct 32/34/36/37/42 → 0010/0110/0000/0001/0111.
  - ALUOp 4/5/6/7 → 1000/1001/1010/1011.
  - Anything else, including md functs, → 0000. No latches.
- **Md functs** (ALUOp 3 only): 24 mult, 25 multu, 26 div, 27 divu, 16 mfhi, 18 mflo.
- **Accept.** An arithmetic md op is accepted when `valid_i` is high and the state is IDLE.
  - At accept, the engine latches operand magnitudes (signed ops only), result signs and the op type.
  - The instruction retires on the accept cycle; `stall_o` stays low.
- **State machine:** IDLE → MUL | DIV → FIX → IDLE.
  - MUL: shift-add, 1 bit/cycle, DATA_W cycles.
  - DIV: restoring, 1 bit/cycle, DATA_W cycles.
  - FIX: one cycle that negates per the latched signs, then writes HI/LO on its closing edge.
- **Results.**
  - Mult: {HI,LO} = 2·DATA_W-bit product, sign = s1^s2 for signed ops.
  - Div: LO = quotient, sign s1^s2. HI = remainder, sign of the dividend.
  - Divide by zero, detected at accept: go straight to FIX; HI = src1, LO = all ones.
  - Signed MIN/−1 needs no special path: LO = MIN, HI = 0.
- **Stall.** `stall_o` = `valid_i` & (md arithmetic or mfhi/mflo) & (state ≠ IDLE). It is combinational.
- **Read.** `md_result_o` = HI for mfhi or LO for mflo when `valid_i` & ¬`stall_o`; otherwise 0.
- **Idle bubbles.** `valid_i` low while busy is allowed; the engine keeps iterating.
- **Reset.** A low `rst_i` at any clock edge, including mid-operation, aborts the op.
  - State → IDLE; HI, LO, iteration counter and all datapath registers → 0.
  - Registered and combinational outputs then read `busy_o` = 0, `stall_o` = 0, `md_result_o` = 0.

## Timing
- Accept at edge E0. `busy_o` is high for the cycles after E0, then low from the cycle after the closing edge:
  - mult/div: high for exactly DATA_W + 1 cycles.
  - Divide by zero: high for 1 cycle.
- HI/LO are valid in the first cycle `busy_o` is low. An mfhi/mflo waiting in EX stalls until then and reads the new value that cycle; no extra bubble.
- A second md op arriving while busy stalls and is accepted on the cycle the state returns to IDLE.
- Iteration counter width: clog2(DATA_W). It wraps to 0 on the MUL/DIV → FIX transition.

## Structure
- **Package `alu_ctrl_pkg`:**
  - ALUCtrl code constants.
  - ALUOp constants.
  - Funct constants for the R-type and md functs.
  - md state enum {IDLE, MUL, DIV, FIX}.
  - md op enum.
- **Sub-module `muldiv_seq`:**
  - Contains the FSM, counter, magnitude/sign logic, shift datapath and HI/LO.
  - The top level keeps the decode and stall logic.

## Test plan
- **Decode sweep:** every ALUOp × the listed functs, plus funct 0 → the codes above; funct 0 under ALUOp 3 → 0000.
- **Signed mult:** mult −3 × 7 → after 33 busy cycles, HI = FFFFFFFF, LO = FFFFFFEB. multu FFFFFFFF × 2 → HI = 1, LO = FFFFFFFE.
- **Divides:**
  - divu 100/7 → LO = 14, HI = 2.
  - div −7/2 → LO = FFFFFFFD, HI = FFFFFFFF.
  - div 80000000/FFFFFFFF → LO = 80000000, HI = 0.
- **Divide by zero:** div 5/0 → busy for 1 cycle; HI = 5, LO = FFFFFFFF.
- **Back-to-back hazard:** mult then mflo immediately → `stall_o` high for 33 cycles; mflo then reads the product. A second mult issued while busy is delayed to the IDLE cycle.
- **Reset mid-op:** `rst_i` low at busy cycle 10 → next cycle state IDLE, HI = LO = 0, `busy_o` = `stall_o` = 0; a subsequent mflo returns 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU controller and its
// iterative multiply/divide engine.
package alu_ctrl_pkg;

   // ALU control codes driven to the ALU
   localparam logic [3:0] ALUCTRL_AND = 4'b0000;
   localparam logic [3:0] ALUCTRL_OR  = 4'b0001;
   localparam logic [3:0] ALUCTRL_ADD = 4'b0010;
   localparam logic [3:0] ALUCTRL_SUB = 4'b0110;
   localparam logic [3:0] ALUCTRL_SLT = 4'b0111;
   localparam logic [3:0] ALUCTRL_OP4 = 4'b1000;
   localparam logic [3:0] ALUCTRL_OP5 = 4'b1001;
   localparam logic [3:0] ALUCTRL_OP6 = 4'b1010;
   localparam logic [3:0] ALUCTRL_OP7 = 4'b1011;

   // ALUOp values from the main decoder
   localparam int ALUOP_ADD    = 0;
   localparam int ALUOP_BRANCH = 1;
   localparam int ALUOP_RTYPE  = 3;
   localparam int ALUOP_OP4    = 4;
   localparam int ALUOP_OP5    = 5;
   localparam int ALUOP_OP6    = 6;
   localparam int ALUOP_OP7    = 7;

   // R-type funct values
   localparam int FUNCT_ADD   = 32;
   localparam int FUNCT_SUB   = 34;
   localparam int FUNCT_AND   = 36;
   localparam int FUNCT_OR    = 37;
   localparam int FUNCT_SLT   = 42;
   localparam int FUNCT_MFHI  = 16;
   localparam int FUNCT_MFLO  = 18;
   localparam int FUNCT_MULT  = 24;
   localparam int FUNCT_MULTU = 25;
   localparam int FUNCT_DIV   = 26;
   localparam int FUNCT_DIVU  = 27;

   // Multiply/divide engine state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   // Decoded multiply/divide operation of the EX instruction
   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MFHI  = 3'd5,
      OP_MFLO  = 3'd6
   } md_op_e;

endpackage

// File: rtl/alu_ctrl_md_muldiv_seq.sv
// Sequential multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle, on operand magnitudes; a final FIX cycle applies the
// result signs and writes HI/LO.
module muldiv_seq
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              is_div_i,
   input  logic              is_signed_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic              busy_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int CNT_W = $clog2(DATA_W);

   md_state_e state_q, state_d;

   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                cnt_last;
   logic [DATA_W-1:0]   acc_q;      // product high half / partial remainder
   logic [DATA_W-1:0]   q_q;        // multiplier / dividend shifting to quotient
   logic [DATA_W-1:0]   m_q;        // multiplicand / divisor magnitude
   logic [DATA_W-1:0]   hi_q, lo_q;
   logic                is_div_q;
   logic                neg_lo_q, neg_hi_q;

   logic                s1, s2;
   logic [DATA_W-1:0]   mag1, mag2;
   logic                div_zero;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic                div_ge;
   logic [DATA_W-1:0]   div_diff;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   fix_hi, fix_lo;

   // Two's-complement negation when en is set
   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                  input logic en);
      return en ? -v : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] v,
                                                     input logic en);
      return en ? -v : v;
   endfunction

   assign s1       = is_signed_i & src1_i[DATA_W-1];
   assign s2       = is_signed_i & src2_i[DATA_W-1];
   assign mag1     = cond_neg(src1_i, s1);
   assign mag2     = cond_neg(src2_i, s2);
   assign div_zero = is_div_i & (src2_i == '0);

   assign cnt_last = (cnt_q == CNT_W'(DATA_W - 1));
   assign cnt_nxt  = cnt_last ? '0 : cnt_q + 1'b1;

   // One multiply step: conditional add then shift {acc,q} right
   assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
   // One restoring-divide step: shift in next dividend bit, trial subtract
   assign div_shift = {acc_q, q_q[DATA_W-1]};
   assign div_ge    = (div_shift >= {1'b0, m_q});
   assign div_diff  = div_shift[DATA_W-1:0] - m_q;

   assign prod_fix = cond_neg2({acc_q, q_q}, neg_lo_q);
   assign fix_hi   = is_div_q ? cond_neg(acc_q, neg_hi_q) : prod_fix[2*DATA_W-1:DATA_W];
   assign fix_lo   = is_div_q ? cond_neg(q_q, neg_lo_q)   : prod_fix[DATA_W-1:0];

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_i) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; divide by zero skips iteration entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (div_zero)      state_d = ST_FIX;
               else if (is_div_i) state_d = ST_DIV;
               else               state_d = ST_MUL;
            end
         end
         ST_MUL:  if (cnt_last) state_d = ST_FIX;
         ST_DIV:  if (cnt_last) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: latch magnitudes/signs at accept, iterate, fix signs into HI/LO
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         q_q      <= '0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  cnt_q    <= '0;
                  is_div_q <= is_div_i;
                  if (is_div_i) begin
                     m_q <= mag2;
                     if (div_zero) begin
                        // FIX passes these through unchanged: HI = src1, LO = all ones
                        acc_q    <= src1_i;
                        q_q      <= '1;
                        neg_lo_q <= 1'b0;
                        neg_hi_q <= 1'b0;
                     end else begin
                        acc_q    <= '0;
                        q_q      <= mag1;
                        neg_lo_q <= s1 ^ s2;
                        neg_hi_q <= s1;
                     end
                  end else begin
                     acc_q    <= '0;
                     q_q      <= mag2;
                     m_q      <= mag1;
                     neg_lo_q <= s1 ^ s2;
                     neg_hi_q <= s1 ^ s2;
                  end
               end
            end
            ST_MUL: begin
               acc_q <= mul_sum[DATA_W:1];
               q_q   <= {mul_sum[0], q_q[DATA_W-1:1]};
               cnt_q <= cnt_nxt;
            end
            ST_DIV: begin
               acc_q <= div_ge ? div_diff : div_shift[DATA_W-1:0];
               q_q   <= {q_q[DATA_W-2:0], div_ge};
               cnt_q <= cnt_nxt;
            end
            ST_FIX: begin
               hi_q <= fix_hi;
               lo_q <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign busy_o = (state_q != ST_IDLE);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU controller: ALU control decode, md instruction decode,
// hazard stall toward IF/ID/EX and HI/LO read-out for mfhi/mflo.
module alu_ctrl_md
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int FUNCT_W = 6,
   parameter int ALUOP_W = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [DATA_W-1:0]  src1_i,
   input  logic [DATA_W-1:0]  src2_i,
   output logic [3:0]         ALUCtrl_o,
   output logic               stall_o,
   output logic               busy_o,
   output logic [DATA_W-1:0]  md_result_o
);

   md_op_e            md_op;
   logic              md_arith;
   logic              md_read;
   logic              start;
   logic              is_div;
   logic              is_signed;
   logic              busy;
   logic              stall;
   logic [DATA_W-1:0] hi, lo;

   // ALU control and md op decode; md functs leave ALUCtrl at its default
   always_comb begin
      ALUCtrl_o = ALUCTRL_AND;
      md_op     = OP_NONE;
      case (ALUOp_i)
         ALUOP_W'(ALUOP_ADD):    ALUCtrl_o = ALUCTRL_ADD;
         ALUOP_W'(ALUOP_BRANCH): ALUCtrl_o = ALUCTRL_SLT;
         ALUOP_W'(ALUOP_OP4):    ALUCtrl_o = ALUCTRL_OP4;
         ALUOP_W'(ALUOP_OP5):    ALUCtrl_o = ALUCTRL_OP5;
         ALUOP_W'(ALUOP_OP6):    ALUCtrl_o = ALUCTRL_OP6;
         ALUOP_W'(ALUOP_OP7):    ALUCtrl_o = ALUCTRL_OP7;
         ALUOP_W'(ALUOP_RTYPE): begin
            case (funct_i)
               FUNCT_W'(FUNCT_ADD):   ALUCtrl_o = ALUCTRL_ADD;
               FUNCT_W'(FUNCT_SUB):   ALUCtrl_o = ALUCTRL_SUB;
               FUNCT_W'(FUNCT_AND):   ALUCtrl_o = ALUCTRL_AND;
               FUNCT_W'(FUNCT_OR):    ALUCtrl_o = ALUCTRL_OR;
               FUNCT_W'(FUNCT_SLT):   ALUCtrl_o = ALUCTRL_SLT;
               FUNCT_W'(FUNCT_MULT):  md_op = OP_MULT;
               FUNCT_W'(FUNCT_MULTU): md_op = OP_MULTU;
               FUNCT_W'(FUNCT_DIV):   md_op = OP_DIV;
               FUNCT_W'(FUNCT_DIVU):  md_op = OP_DIVU;
               FUNCT_W'(FUNCT_MFHI):  md_op = OP_MFHI;
               FUNCT_W'(FUNCT_MFLO):  md_op = OP_MFLO;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign md_arith  = (md_op == OP_MULT) | (md_op == OP_MULTU) |
                      (md_op == OP_DIV)  | (md_op == OP_DIVU);
   assign md_read   = (md_op == OP_MFHI) | (md_op == OP_MFLO);
   assign is_div    = (md_op == OP_DIV)  | (md_op == OP_DIVU);
   assign is_signed = (md_op == OP_MULT) | (md_op == OP_DIV);

   // Any md instruction in EX waits while the engine is working
   assign stall = valid_i & (md_arith | md_read) & busy;
   assign start = valid_i & md_arith & ~busy;

   muldiv_seq #(
      .DATA_W (DATA_W)
   ) u_muldiv_seq (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start),
      .is_div_i    (is_div),
      .is_signed_i (is_signed),
      .src1_i      (src1_i),
      .src2_i      (src2_i),
      .busy_o      (busy),
      .hi_o        (hi),
      .lo_o        (lo)
   );

   // HI/LO read port, zero unless a non-stalled mfhi/mflo is in EX
   always_comb begin
      md_result_o = '0;
      if (valid_i && !stall) begin
         if (md_op == OP_MFHI)      md_result_o = hi;
         else if (md_op == OP_MFLO) md_result_o = lo;
      end
   end

   assign stall_o = stall;
   assign busy_o  = busy;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Self-checking bench for alu_ctrl_md: directed decode/md cases plus random
// md operations checked against an arithmetic reference model.
module tb_alu_ctrl_md;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic [2:0]  ALUOp_i;
   logic [5:0]  funct_i;
   logic [31:0] src1_i, src2_i;
   logic [3:0]  ALUCtrl_o;
   logic        stall_o;
   logic        busy_o;
   logic [31:0] md_result_o;

   int checks   = 0;
   int failures = 0;

   alu_ctrl_md #(
      .DATA_W  (32),
      .FUNCT_W (6),
      .ALUOP_W (3)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ALUOp_i     (ALUOp_i),
      .funct_i     (funct_i),
      .src1_i      (src1_i),
      .src2_i      (src2_i),
      .ALUCtrl_o   (ALUCtrl_o),
      .stall_o     (stall_o),
      .busy_o      (busy_o),
      .md_result_o (md_result_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected ALU control code from the decode table
   function automatic logic [3:0] exp_ctrl(input int op, input int fn);
      if (op == 0) return 4'b0010;
      if (op == 1) return 4'b0111;
      if (op >= 4) return 4'(8 + op - 4);
      if (op == 3) begin
         case (fn)
            32: return 4'b0010;
            34: return 4'b0110;
            36: return 4'b0000;
            37: return 4'b0001;
            42: return 4'b0111;
            default: return 4'b0000;
         endcase
      end
      return 4'b0000;
   endfunction

   // Reference HI/LO from plain 64-bit arithmetic
   task automatic model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
      longint      p, qa, qb, q, r;
      logic [63:0] u;
      hi = '0;
      lo = '0;
      case (fn)
         6'd24: begin
            p  = longint'($signed(a)) * longint'($signed(b));
            hi = p[63:32];
            lo = p[31:0];
         end
         6'd25: begin
            u  = {32'b0, a} * {32'b0, b};
            hi = u[63:32];
            lo = u[31:0];
         end
         6'd26: begin
            if (b == 0) begin
               hi = a;
               lo = '1;
            end else begin
               qa = longint'($signed(a));
               qb = longint'($signed(b));
               q  = qa / qb;
               r  = qa % qb;
               hi = r[31:0];
               lo = q[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               hi = a;
               lo = '1;
            end else begin
               hi = a % b;
               lo = a / b;
            end
         end
      endcase
   endtask

   // Read HI then LO through mfhi/mflo while idle
   task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      valid_i = 1'b1;
      ALUOp_i = 3'd3;
      funct_i = 6'd16;
      #1;
      check({tag, "_mfhi_stall"}, stall_o, 0);
      check({tag, "_hi"}, md_result_o, exp_hi);
      funct_i = 6'd18;
      #1;
      check({tag, "_lo"}, md_result_o, exp_lo);
      valid_i = 1'b0;
      funct_i = 6'd0;
      #1;
   endtask

   // Issue one md op, count busy cycles, then read HI/LO
   task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int exp_busy);
      int n;
      valid_i = 1'b1;
      ALUOp_i = 3'd3;
      funct_i = fn;
      src1_i  = a;
      src2_i  = b;
      #1;
      check({tag, "_accept_stall"}, stall_o, 0);
      tick();
      valid_i = 1'b0;
      funct_i = 6'd0;
      n = 0;
      while (busy_o && n < 200) begin
         n++;
         tick();
      end
      check({tag, "_busy_cycles"}, n, exp_busy);
      read_hilo(tag, exp_hi, exp_lo);
   endtask

   initial begin
      int          fn_list[8];
      int          n;
      logic [5:0]  fn;
      logic [31:0] a, b, eh, el, eh2, el2;

      fn_list = '{32, 34, 36, 37, 42, 0, 24, 16};

      // Reset state
      rst_i   = 1'b0;
      valid_i = 1'b0;
      ALUOp_i = 3'd0;
      funct_i = 6'd0;
      src1_i  = '0;
      src2_i  = '0;
      tick();
      tick();
      valid_i = 1'b1;
      ALUOp_i = 3'd3;
      funct_i = 6'd16;
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_mfhi", md_result_o, 0);
      funct_i = 6'd18;
      #1;
      check("rst_mflo", md_result_o, 0);
      valid_i = 1'b0;
      rst_i   = 1'b1;
      tick();

      // Decode sweep (valid low so md functs do not start the engine)
      for (int op = 0; op < 8; op++) begin
         for (int k = 0; k < 8; k++) begin
            ALUOp_i = 3'(op);
            funct_i = 6'(fn_list[k]);
            #1;
            check($sformatf("decode_op%0d_fn%0d", op, fn_list[k]), ALUCtrl_o,
                  exp_ctrl(op, fn_list[k]));
         end
      end
      check("decode_no_start", busy_o, 0);

      // Non-md instruction yields zero read data
      valid_i = 1'b1;
      ALUOp_i = 3'd0;
      funct_i = 6'd16;
      #1;
      check("result_non_md", md_result_o, 0);
      valid_i = 1'b0;
      tick();

      // Directed arithmetic cases
      run_md("mult_neg",   6'd24, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33);
      run_md("multu_max",  6'd25, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 33);
      run_md("divu_100_7", 6'd27, 32'd100,      32'd7,        32'd2,        32'd14,       33);
      run_md("div_m7_2",   6'd26, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      run_md("div_min_m1", 6'd26, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
      run_md("div_by0",    6'd26, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1);
      run_md("divu_by0",   6'd27, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hFFFFFFFF, 1);

      // Back-to-back: mflo right after mult stalls until the product is ready
      a = 32'd12345;
      b = 32'hFFFFF000;
      model(6'd24, a, b, eh, el);
      valid_i = 1'b1;
      ALUOp_i = 3'd3;
      funct_i = 6'd24;
      src1_i  = a;
      src2_i  = b;
      tick();
      funct_i = 6'd18;
      #1;
      n = 0;
      while (stall_o && n < 200) begin
         n++;
         tick();
      end
      check("hazard_mflo_stall_cycles", n, 33);
      check("hazard_mflo_value", md_result_o, el);
      tick();
      valid_i = 1'b0;

      // Second mult issued while busy is held off until IDLE
      a = 32'd1000;
      b = 32'd3000;
      model(6'd25, 32'hABCD1234, 32'h00FF00FF, eh2, el2);
      valid_i = 1'b1;
      funct_i = 6'd24;
      src1_i  = a;
      src2_i  = b;
      tick();
      funct_i = 6'd25;
      src1_i  = 32'hABCD1234;
      src2_i  = 32'h00FF00FF;
      #1;
      n = 0;
      while (stall_o && n < 200) begin
         n++;
         tick();
      end
      check("hazard_mult2_stall_cycles", n, 33);
      check("hazard_mult2_idle", busy_o, 0);
      tick();
      valid_i = 1'b0;
      funct_i = 6'd0;
      n = 0;
      while (busy_o && n < 200) begin
         n++;
         tick();
      end
      check("hazard_mult2_busy_cycles", n, 33);
      read_hilo("hazard_mult2", eh2, el2);

      // Reset in the middle of an operation
      valid_i = 1'b1;
      ALUOp_i = 3'd3;
      funct_i = 6'd24;
      src1_i  = 32'h12345678;
      src2_i  = 32'h9ABCDEF0;
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("midrst_busy_before", busy_o, 1);
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      #1;
      check("midrst_busy", busy_o, 0);
      valid_i = 1'b1;
      funct_i = 6'd18;
      #1;
      check("midrst_stall", stall_o, 0);
      valid_i = 1'b0;
      read_hilo("midrst", 32'd0, 32'd0);
      tick();

      // Random md operations against the reference model
      for (int i = 0; i < 24; i++) begin
         fn = 6'(24 + $urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
         model(fn, a, b, eh, el);
         run_md($sformatf("rand%0d_fn%0d", i, fn), fn, a, b, eh, el,
                (fn >= 6'd26 && b == 0) ? 1 : 33);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
